// File: rtl/rpu_sensor_scheduler.sv
// Round-robin front end that feeds sensor samples from NCH requesters to a single RPU,
// waits a fixed settle time and returns the motor command tagged with the owning channel.
module rpu_sensor_scheduler #(
   parameter int NCH    = 4,
   parameter int DW     = 8,
   parameter int SETTLE = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NCH-1:0]           ch_valid,
   input  logic [NCH*DW-1:0]        ch_data,
   output logic [NCH-1:0]           ch_ready,
   output logic                     rpu_start,
   output logic [DW-1:0]            rpu_sensor_data,
   output logic                     rpu_data_valid,
   input  logic [DW-1:0]            rpu_motor_command,
   output logic                     cmd_valid,
   output logic [$clog2(NCH)-1:0]   cmd_ch,
   output logic [DW-1:0]            cmd_data,
   output logic                     busy
);

   localparam int IW = $clog2(NCH);

   typedef enum logic [2:0] {
      INIT,
      GAP,
      IDLE,
      ISSUE,
      WAIT,
      CAPTURE
   } state_e;

   state_e          state_q;
   logic [IW-1:0]   rrPtr_q;
   logic [IW-1:0]   rrPtr_d;
   logic [IW-1:0]   chIdx_q;
   logic [IW-1:0]   cmdCh_q;
   logic [DW-1:0]   sample_q;
   logic [DW-1:0]   cmdData_q;
   logic [3:0]      cnt_q;

   logic            grantValid;
   logic [IW-1:0]   grantIdx;
   logic [IW-1:0]   scanIdx;

   // Scan upward from the pointer so the channel after the last winner gets first look.
   always_comb begin
      grantValid = 1'b0;
      grantIdx   = '0;
      scanIdx    = '0;
      for (int k = 0; k < NCH; k++) begin
         scanIdx = IW'((int'(rrPtr_q) + k) % NCH);
         if (!grantValid && ch_valid[scanIdx]) begin
            grantValid = 1'b1;
            grantIdx   = scanIdx;
         end
      end
      rrPtr_d = (grantIdx == IW'(NCH - 1)) ? '0 : grantIdx + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= INIT;
         rrPtr_q   <= '0;
         chIdx_q   <= '0;
         cmdCh_q   <= '0;
         sample_q  <= '0;
         cmdData_q <= '0;
         cnt_q     <= '0;
      end else begin
         case (state_q)
            INIT: begin
               cnt_q   <= 4'd1;
               state_q <= GAP;
            end
            GAP: begin
               if (cnt_q == 4'd0) state_q <= IDLE;
               else               cnt_q   <= cnt_q - 4'd1;
            end
            IDLE: begin
               if (grantValid) begin
                  sample_q <= ch_data[int'(grantIdx)*DW +: DW];
                  chIdx_q  <= grantIdx;
                  rrPtr_q  <= rrPtr_d;
                  state_q  <= ISSUE;
               end
            end
            ISSUE: begin
               cnt_q   <= 4'(SETTLE - 1);
               state_q <= WAIT;
            end
            WAIT: begin
               if (cnt_q == 4'd0) state_q <= CAPTURE;
               else               cnt_q   <= cnt_q - 4'd1;
            end
            CAPTURE: begin
               cmdData_q <= rpu_motor_command;
               cmdCh_q   <= chIdx_q;
               state_q   <= IDLE;
            end
            default: state_q <= INIT;
         endcase
      end
   end

   // The result is forwarded in the capture cycle itself and then held from the registers.
   assign ch_ready        = (state_q == IDLE && grantValid) ? ({{(NCH-1){1'b0}}, 1'b1} << grantIdx) : '0;
   assign rpu_start       = (state_q == INIT) && !rst;
   assign rpu_data_valid  = (state_q == ISSUE);
   assign rpu_sensor_data = sample_q;
   assign cmd_valid       = (state_q == CAPTURE);
   assign cmd_data        = cmd_valid ? rpu_motor_command : cmdData_q;
   assign cmd_ch          = cmd_valid ? chIdx_q : cmdCh_q;
   assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_rpu_sensor_scheduler.sv
// Directed bench for rpu_sensor_scheduler with a trivial RPU model that returns sample+1.
module tb_rpu_sensor_scheduler;

   logic        clk;
   logic        rst;
   logic [3:0]  ch_valid;
   logic [31:0] ch_data;
   logic [3:0]  ch_ready;
   logic        rpu_start;
   logic [7:0]  rpu_sensor_data;
   logic        rpu_data_valid;
   logic [7:0]  rpu_motor_command;
   logic        cmd_valid;
   logic [1:0]  cmd_ch;
   logic [7:0]  cmd_data;
   logic        busy;

   int cmpCount = 0;
   int errCount = 0;
   int cycleNo  = 0;

   rpu_sensor_scheduler #(.NCH(4), .DW(8), .SETTLE(4)) dut (
      .clk               (clk),
      .rst               (rst),
      .ch_valid          (ch_valid),
      .ch_data           (ch_data),
      .ch_ready          (ch_ready),
      .rpu_start         (rpu_start),
      .rpu_sensor_data   (rpu_sensor_data),
      .rpu_data_valid    (rpu_data_valid),
      .rpu_motor_command (rpu_motor_command),
      .cmd_valid         (cmd_valid),
      .cmd_ch            (cmd_ch),
      .cmd_data          (cmd_data),
      .busy              (busy)
   );

   assign rpu_motor_command = rpu_sensor_data + 8'd1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cycleNo <= cycleNo + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      cmpCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d);
      ch_valid = v;
      ch_data  = d;
      #1;
   endtask

   task automatic waitAccept(input int budget, output logic [3:0] rdy, output int when);
      int n = 0;
      while (ch_ready == 4'b0 && n < budget) begin
         tick();
         n++;
      end
      rdy  = ch_ready;
      when = cycleNo;
   endtask

   task automatic waitIdle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      checkOutput("reach-idle", busy, 0);
   endtask

   task automatic restart();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      tick();
      tick();
      checkOutput("restart-idle", busy, 0);
   endtask

   initial begin
      logic [3:0] rdy;
      int when;
      int prev;

      rst      = 1'b1;
      ch_valid = 4'b0;
      ch_data  = 32'b0;

      // Startup: two reset cycles, then the start pulse and the two-cycle gap
      tick();
      tick();
      checkOutput("rst-busy", busy, 1);
      checkOutput("rst-ready", ch_ready, 0);
      checkOutput("rst-start", rpu_start, 0);
      checkOutput("rst-dvalid", rpu_data_valid, 0);
      checkOutput("rst-sdata", rpu_sensor_data, 0);
      checkOutput("rst-cvalid", cmd_valid, 0);
      checkOutput("rst-cch", cmd_ch, 0);
      checkOutput("rst-cdata", cmd_data, 0);
      rst = 1'b0;
      #1;
      checkOutput("start-pulse", rpu_start, 1);
      tick();
      checkOutput("start-drop", rpu_start, 0);
      checkOutput("gap1-busy", busy, 1);
      tick();
      checkOutput("gap2-busy", busy, 1);
      checkOutput("gap2-dvalid", rpu_data_valid, 0);
      tick();
      checkOutput("idle-busy", busy, 0);

      // Single request on channel 0
      applyStimulus(4'b0001, 32'd55);
      checkOutput("single-ready", ch_ready, 4'b0001);
      tick();
      applyStimulus(4'b0000, 32'd0);
      checkOutput("single-dvalid", rpu_data_valid, 1);
      checkOutput("single-sdata", rpu_sensor_data, 55);
      checkOutput("single-issue-ready", ch_ready, 0);
      for (int i = 0; i < 4; i++) tick();
      checkOutput("single-early-cvalid", cmd_valid, 0);
      checkOutput("single-hold-sdata", rpu_sensor_data, 55);
      tick();
      checkOutput("single-cvalid", cmd_valid, 1);
      checkOutput("single-cch", cmd_ch, 0);
      checkOutput("single-cdata", cmd_data, 56);
      tick();
      checkOutput("single-cvalid-drop", cmd_valid, 0);
      checkOutput("single-cdata-hold", cmd_data, 56);
      checkOutput("single-back-idle", busy, 0);

      // Reset during WAIT aborts the channel 1 transaction
      applyStimulus(4'b0010, {16'd0, 8'd20, 8'd0});
      checkOutput("abort-ready", ch_ready, 4'b0010);
      tick();
      applyStimulus(4'b0000, 32'd0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      checkOutput("abort-cvalid", cmd_valid, 0);
      checkOutput("abort-sdata", rpu_sensor_data, 0);
      checkOutput("abort-busy", busy, 1);
      rst = 1'b0;
      #1;
      checkOutput("abort-restart", rpu_start, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("abort-no-cvalid", cmd_valid, 0);
      end
      checkOutput("abort-idle", busy, 0);
      applyStimulus(4'b0100, {8'd0, 8'd100, 16'd0});
      checkOutput("after-abort-ready", ch_ready, 4'b0100);
      tick();
      applyStimulus(4'b0000, 32'd0);
      checkOutput("after-abort-sdata", rpu_sensor_data, 100);
      for (int i = 0; i < 5; i++) tick();
      checkOutput("after-abort-cvalid", cmd_valid, 1);
      checkOutput("after-abort-cch", cmd_ch, 2);
      checkOutput("after-abort-cdata", cmd_data, 101);
      tick();

      // Pointer now sits at 3: grant 3 first, then wrap to 0
      applyStimulus(4'b1001, {8'd33, 16'd0, 8'd11});
      checkOutput("wrap-first", ch_ready, 4'b1000);
      prev = cycleNo;
      tick();
      waitAccept(20, rdy, when);
      checkOutput("wrap-second", rdy, 4'b0001);
      checkOutput("wrap-spacing", when - prev, 7);
      tick();
      applyStimulus(4'b0000, 32'd0);
      waitIdle(20);
      checkOutput("wrap-cch", cmd_ch, 0);
      checkOutput("wrap-cdata", cmd_data, 12);

      // Channel 1 raised only while WAIT is in progress must never be served
      applyStimulus(4'b0100, {8'd0, 8'd7, 16'd0});
      checkOutput("late-ready-ch2", ch_ready, 4'b0100);
      tick();
      applyStimulus(4'b0000, 32'd0);
      tick();
      applyStimulus(4'b0010, {16'd0, 8'd9, 8'd0});
      checkOutput("late-ready-wait1", ch_ready, 0);
      tick();
      checkOutput("late-ready-wait2", ch_ready, 0);
      applyStimulus(4'b0000, 32'd0);
      for (int i = 0; i < 4; i++) tick();
      checkOutput("late-idle", busy, 0);
      checkOutput("late-idle-ready", ch_ready, 0);
      checkOutput("late-cch", cmd_ch, 2);
      tick();
      checkOutput("late-never-busy", busy, 0);
      checkOutput("late-no-dvalid", rpu_data_valid, 0);

      // Round robin from a fresh pointer with all four held high
      restart();
      applyStimulus(4'b1111, {8'd4, 8'd3, 8'd2, 8'd1});
      prev = 0;
      for (int i = 0; i < 5; i++) begin
         waitAccept(20, rdy, when);
         checkOutput($sformatf("rr-grant%0d", i), rdy, 32'd1 << (i % 4));
         if (i > 0) checkOutput($sformatf("rr-spacing%0d", i), when - prev, 7);
         prev = when;
         tick();
      end
      applyStimulus(4'b0000, 32'd0);
      waitIdle(20);
      checkOutput("rr-last-cch", cmd_ch, 0);
      checkOutput("rr-last-cdata", cmd_data, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
      $finish;
   end

endmodule
